kw4281_capture: RTL

Receive-side counterpart of the KW4281 4-digit multiplexed 7-segment driver. Samples the active-low anode and segment lines, rejects transients and invalid patterns, decodes each digit back to a hex nibble, and assembles complete 16-bit frames. Used in self-test loopback (driver pins wired back into the FPGA) and as a bench-side monitor for driver verification.

---
 rtl/kw4281_capture.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/kw4281_capture.sv
// Receive-side capture for the KW4281 multiplexed 7-segment driver: conditions the
// active-low anode/segment lines, decodes each settled digit and assembles 16-bit frames.
module kw4281_capture #(
    parameter int unsigned CLOCK_FREQUENCY = 100_000_000,
    parameter int unsigned SETTLE_CYCLES   = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  an_i,
    input  logic [6:0]  seg_i,
    output logic [15:0] hex_o,
    output logic        valid_o,
    output logic        err_o
);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255 || CLOCK_FREQUENCY == 0) begin : gen_bad_param
        $error("kw4281_capture: SETTLE_CYCLES must be 1..255 and CLOCK_FREQUENCY nonzero");
    end

    localparam logic [7:0] SettleLast = 8'(SETTLE_CYCLES - 1);
    localparam logic [7:0] SettleMax  = 8'(SETTLE_CYCLES);

    // Map a segment pattern to {legal, nibble}; anything outside the 16 glyphs is illegal.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'b1000000: res = 5'h10;
            7'b1111001: res = 5'h11;
            7'b0100100: res = 5'h12;
            7'b0110000: res = 5'h13;
            7'b0011001: res = 5'h14;
            7'b0010010: res = 5'h15;
            7'b0000010: res = 5'h16;
            7'b1111000: res = 5'h17;
            7'b0000000: res = 5'h18;
            7'b0010000: res = 5'h19;
            7'b0001000: res = 5'h1A;
            7'b0000011: res = 5'h1B;
            7'b1000110: res = 5'h1C;
            7'b0100001: res = 5'h1D;
            7'b0000110: res = 5'h1E;
            7'b0001110: res = 5'h1F;
            default:    res = 5'h00;
        endcase
        return res;
    endfunction

    logic [10:0] sync1_q, sync2_q, prev_q;
    logic [7:0]  cnt_q, cnt_d;
    logic [15:0] sh_q, sh_d;
    logic [3:0]  mask_q, mask_d;
    logic [15:0] hex_q, hex_d;
    logic        valid_q, valid_d;
    logic        err_q, err_d;

    logic        stable;
    logic        strobe;
    logic [3:0]  an_s;
    logic [6:0]  seg_s;
    logic [1:0]  digit_idx;
    logic        an_legal;
    logic        an_blank;
    logic [4:0]  glyph;
    logic [3:0]  mask_new;

    assign an_s   = sync2_q[10:7];
    assign seg_s  = sync2_q[6:0];
    assign stable = (sync2_q == prev_q);
    // Counter saturates past SettleLast, so a long stable period strobes exactly once.
    assign strobe = stable && (cnt_q == SettleLast);
    assign glyph  = decode_glyph(seg_s);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= {an_i, seg_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!stable) begin
            cnt_d = '0;
        end else if (cnt_q < SettleMax) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_comb begin
        digit_idx = 2'd0;
        an_legal  = 1'b0;
        an_blank  = 1'b0;
        case (an_s)
            4'b1110: begin digit_idx = 2'd0; an_legal = 1'b1; end
            4'b1101: begin digit_idx = 2'd1; an_legal = 1'b1; end
            4'b1011: begin digit_idx = 2'd2; an_legal = 1'b1; end
            4'b0111: begin digit_idx = 2'd3; an_legal = 1'b1; end
            4'b1111: an_blank = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        sh_d     = sh_q;
        mask_d   = mask_q;
        hex_d    = hex_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
        mask_new = mask_q | (4'b0001 << digit_idx);
        if (strobe && !an_blank) begin
            if (!an_legal || !glyph[4]) begin
                // Partial frame is discarded; last good frame stays visible.
                err_d  = 1'b1;
                mask_d = '0;
            end else begin
                sh_d[{digit_idx, 2'b00} +: 4] = glyph[3:0];
                if (&mask_new) begin
                    hex_d   = sh_d;
                    valid_d = 1'b1;
                    mask_d  = '0;
                end else begin
                    mask_d = mask_new;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sh_q    <= '0;
            mask_q  <= '0;
            hex_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sh_q    <= sh_d;
            mask_q  <= mask_d;
            hex_q   <= hex_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign hex_o   = hex_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule
